mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store front end sitting directly upstream of mem_bus. It receives one RV32E load/store request from the core and drives the mem_bus start_request / request_done handshake.
- Applies size encoding, alignment checking, store-data masking, and load sign/zero extension.
- Aborts a bus transaction that never completes, using a timeout.

Parameters:
- address_size, 18, width of the bus address. MSB=1 selects the IO region; MSB-1 selects RAM (1) or flash (0).
- TIMEOUT_CYCLES, 4096, maximum cycles spent waiting for request_done in REQ. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request strobe; sampled only in IDLE.
- req_is_store  in  1  1=store, 0=load.
- req_funct3  in  3  RV funct3 access size/extension code.
- req_addr  in  address_size  byte address.
- req_store_data  in  32  store data, right-aligned.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid only while done=1; flags misalignment, an illegal funct3, or a timeout.
- load_data  out  32  extended load result; holds its value until the next successful load.
- bus_start_request  out  1  to mem_bus start_request.
- bus_is_write  out  1  to mem_bus is_write.
- bus_num_bytes  out  3  to mem_bus num_bytes; takes values 1, 2 or 4.
- bus_target_address  out  address_size  to mem_bus target_address.
- bus_write_value  out  32  to mem_bus write_value.
- bus_request_done  in  1  from mem_bus request_done.
- bus_fetched_value  in  32  from mem_bus fetched_value; bits[7:0] hold the byte at the lowest address.

Behaviour:
- Reset: state=IDLE. busy, done, error, bus_start_request and bus_is_write all go to 0. bus_num_bytes=1. bus_target_address, bus_write_value and load_data go to 0. Timeout counter goes to 0. All outputs are registered.
- Reset mid-operation clears bus_start_request immediately. mem_bus then returns to its parse state by itself.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other code is illegal.
- Alignment rules:
  - Halfword accesses require addr[0]=0.
  - Word accesses require addr[1:0]=00.
  - The alignment check applies in both the memory and IO regions.
- IDLE:
  - On req_valid=1, latch all req_* inputs and set busy=1 on the next cycle.
  - If the request is illegal or misaligned, go to ERR. No bus activity occurs.
  - Otherwise go to REQ. In the same cycle, drive bus_is_write, bus_num_bytes, bus_target_address and bus_write_value.
  - bus_write_value = store data masked to the access size, with upper bits zero.
- REQ:
  - bus_start_request=1; all bus_* outputs are held stable.
  - The timeout counter increments each cycle.
  - On bus_request_done=1 (checked first):
    - For a load, load_data is set to the extended bus_fetched_value. LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes all 32 bits.
    - done=1 and error=0 are pulsed for one cycle.
    - bus_start_request=0 from the next cycle. Go to RELEASE.
  - Otherwise, if the counter reaches TIMEOUT_CYCLES-1:
    - bus_start_request=0.
    - done=1 and error=1 for one cycle.
    - load_data is unchanged. Go to RELEASE.
  - If done and the timeout coincide, done wins and the transfer counts as a success.
- ERR: done=1 and error=1 for one cycle, then go to IDLE. Latency from req_valid to done is 2 cycles.
- RELEASE:
  - bus_start_request is held at 0.
  - Stay until bus_request_done=0, then clear the counter and go to IDLE. This guarantees at least one low cycle of start_request between requests.
- Latency: done rises 1 cycle after bus_request_done is sampled high. The best-case turnaround from req_valid to a new accepted request is done+2 cycles.
- req_valid is ignored while busy=1; the core must hold or reissue the request.

Test Plan:
- LW addr 0x00010, bus returns done after 20 cycles with fetched 0xDEADBEEF -> bus_num_bytes=4, start held 20 cycles; done pulse with error=0 and load_data=0xDEADBEEF.
- LB/LBU addr 0x00003, fetched 0x00000080 -> LB gives load_data=0xFFFFFF80; LBU gives 0x00000080. LH with fetched 0x00008001 gives 0xFFFF8001.
- SH addr 0x10002 (RAM), store_data 0x12345678 -> bus_is_write=1, num_bytes=2, write_value=0x00005678; done with error=0.
- LW addr 0x00002, and funct3=011 -> no start_request ever asserted; done+error 2 cycles after req_valid.
- Bus never answers, TIMEOUT_CYCLES=16 -> start deasserts after 16 cycles in REQ; done+error; busy stays high until bus_request_done is low.
- Assert rst during REQ -> bus_start_request drops before the next clock edge. After release, a request to IO addr 0x20001 with LBU completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end for mem_bus: validates an RV32E load/store request, drives the
// start_request/request_done handshake, and formats store data and load results.
module mem_access_unit #(
    parameter int address_size   = 18,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic                    req_is_store,
    input  logic [2:0]              req_funct3,
    input  logic [address_size-1:0] req_addr,
    input  logic [31:0]             req_store_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [31:0]             load_data,
    output logic                    bus_start_request,
    output logic                    bus_is_write,
    output logic [2:0]              bus_num_bytes,
    output logic [address_size-1:0] bus_target_address,
    output logic [31:0]             bus_write_value,
    input  logic                    bus_request_done,
    input  logic [31:0]             bus_fetched_value
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ERR,
        S_RELEASE
    } state_e;

    localparam int          CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned CNT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

    state_e                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic [31:0]             load_data_q, load_data_d;
    logic                    start_q, start_d;
    logic                    is_write_q, is_write_d;
    logic [2:0]              num_bytes_q, num_bytes_d;
    logic [address_size-1:0] addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [2:0]              funct3_q, funct3_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic        req_legal;
    logic        req_aligned;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [31:0] load_ext;

    // Request decode: legality of funct3, access size, alignment and store-data masking.
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        req_size    = 3'd4;
        req_wdata   = req_store_data;
        if (req_is_store) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                default:                                req_legal = 1'b0;
            endcase
        end
        case (req_funct3[1:0])
            2'b00: begin
                req_size  = 3'd1;
                req_wdata = {24'b0, req_store_data[7:0]};
            end
            2'b01: begin
                req_size    = 3'd2;
                req_aligned = ~req_addr[0];
                req_wdata   = {16'b0, req_store_data[15:0]};
            end
            default: begin
                req_aligned = (req_addr[1:0] == 2'b00);
            end
        endcase
    end

    always_comb begin
        case (funct3_q)
            3'b000:  load_ext = {{24{bus_fetched_value[7]}}, bus_fetched_value[7:0]};
            3'b001:  load_ext = {{16{bus_fetched_value[15]}}, bus_fetched_value[15:0]};
            3'b100:  load_ext = {24'b0, bus_fetched_value[7:0]};
            3'b101:  load_ext = {16'b0, bus_fetched_value[15:0]};
            default: load_ext = bus_fetched_value;
        endcase
    end

    always_comb begin
        // NOTE: every _d starts from its _q (done/error from 0) so no path can infer a latch.
        state_d     = state_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        load_data_d = load_data_q;
        start_d     = start_q;
        is_write_d  = is_write_q;
        num_bytes_d = num_bytes_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        cnt_d       = cnt_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req_valid) begin
                    funct3_d = req_funct3;
                    if (req_legal && req_aligned) begin
                        state_d     = S_REQ;
                        start_d     = 1'b1;
                        is_write_d  = req_is_store;
                        num_bytes_d = req_size;
                        addr_d      = req_addr;
                        wdata_d     = req_wdata;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 1'b1;
                // A completion in the same cycle as the timeout wins.
                if (bus_request_done) begin
                    if (!is_write_q) begin
                        load_data_d = load_ext;
                    end
                    done_d  = 1'b1;
                    start_d = 1'b0;
                    state_d = S_RELEASE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    start_d = 1'b0;
                    state_d = S_RELEASE;
                end
            end
            S_ERR: begin
                done_d  = 1'b1;
                error_d = 1'b1;
                state_d = S_IDLE;
            end
            S_RELEASE: begin
                start_d = 1'b0;
                if (!bus_request_done) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state is only ever assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            load_data_q <= '0;
            start_q     <= 1'b0;
            is_write_q  <= 1'b0;
            num_bytes_q <= 3'd1;
            addr_q      <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            load_data_q <= load_data_d;
            start_q     <= start_d;
            is_write_q  <= is_write_d;
            num_bytes_q <= num_bytes_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            cnt_q       <= cnt_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign error              = error_q;
    assign load_data          = load_data_q;
    assign bus_start_request  = start_q;
    assign bus_is_write       = is_write_q;
    assign bus_num_bytes      = num_bytes_q;
    assign bus_target_address = addr_q;
    assign bus_write_value    = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: acts as mem_bus, drives directed and random load/store
// requests into a default instance and a short-timeout instance, and checks a reference model.
module tb_mem_access_unit;

    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_is_store;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_store_data;
    logic          bus_request_done;
    logic [31:0]   bus_fetched_value;

    // Instance 0 uses the default timeout, instance 1 a 16-cycle timeout; sel picks the one under test.
    bit            sel;
    logic [1:0]    rv_w, busy_w, done_w, error_w, start_w, is_write_w;
    logic [31:0]   load_data_w [2];
    logic [2:0]    num_bytes_w [2];
    logic [AW-1:0] target_w    [2];
    logic [31:0]   wvalue_w    [2];

    logic          busy, done, error, bus_start_request, bus_is_write;
    logic [31:0]   load_data, bus_write_value;
    logic [2:0]    bus_num_bytes;
    logic [AW-1:0] bus_target_address;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_load [2];

    always #5 clk = ~clk;

    assign rv_w[0] = req_valid & ~sel;
    assign rv_w[1] = req_valid & sel;

    mem_access_unit dut0 (
        .clk(clk), .rst(rst), .req_valid(rv_w[0]), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
        .busy(busy_w[0]), .done(done_w[0]), .error(error_w[0]), .load_data(load_data_w[0]),
        .bus_start_request(start_w[0]), .bus_is_write(is_write_w[0]),
        .bus_num_bytes(num_bytes_w[0]), .bus_target_address(target_w[0]),
        .bus_write_value(wvalue_w[0]), .bus_request_done(bus_request_done),
        .bus_fetched_value(bus_fetched_value)
    );

    mem_access_unit #(.address_size(AW), .TIMEOUT_CYCLES(16)) dut1 (
        .clk(clk), .rst(rst), .req_valid(rv_w[1]), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_store_data(req_store_data),
        .busy(busy_w[1]), .done(done_w[1]), .error(error_w[1]), .load_data(load_data_w[1]),
        .bus_start_request(start_w[1]), .bus_is_write(is_write_w[1]),
        .bus_num_bytes(num_bytes_w[1]), .bus_target_address(target_w[1]),
        .bus_write_value(wvalue_w[1]), .bus_request_done(bus_request_done),
        .bus_fetched_value(bus_fetched_value)
    );

    always_comb begin
        busy               = busy_w[sel];
        done               = done_w[sel];
        error              = error_w[sel];
        load_data          = load_data_w[sel];
        bus_start_request  = start_w[sel];
        bus_is_write       = is_write_w[sel];
        bus_num_bytes      = num_bytes_w[sel];
        bus_target_address = target_w[sel];
        bus_write_value    = wvalue_w[sel];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: plain arithmetic on access size in bytes.
    function automatic bit model_legal(input bit st, input logic [2:0] f3, input logic [AW-1:0] a);
        bit code_ok;
        int size;
        if (st) code_ok = f3 inside {3'd0, 3'd1, 3'd2};
        else    code_ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        size = 1 << f3[1:0];
        return code_ok && ((int'(a) % size) == 0);
    endfunction

    function automatic logic [31:0] model_wvalue(input logic [2:0] f3, input logic [31:0] d);
        longint one = 1;
        longint range = one << (8 * (1 << f3[1:0]));
        longint v = {32'b0, d} % range;
        return v[31:0];
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] fetched);
        longint one = 1;
        int     bits = 8 * (1 << f3[1:0]);
        longint range = one << bits;
        longint v = {32'b0, fetched} % range;
        if (!f3[2] && bits < 32 && v >= (one << (bits - 1))) v = v - range;
        return v[31:0];
    endfunction

    // One request at a negedge. delay = cycles start_request stays high before the bus answers; 0 = never.
    task automatic run_txn(input bit st, input logic [2:0] f3, input logic [AW-1:0] addr,
                           input logic [31:0] data, input int delay, input logic [31:0] fetched);
        int  to, hold;
        bit  legal, success;
        legal   = model_legal(st, f3, addr);
        to      = sel ? 16 : 4096;
        success = (delay != 0) && (delay <= to);
        hold    = success ? delay : to;

        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_store_data = data;
        @(negedge clk);
        req_valid = 1'b0;
        req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = AW'($urandom); req_store_data = $urandom;
        check("busy_after_accept", busy, 1);

        if (!legal) begin
            check("err_no_start", bus_start_request, 0);
            check("err_no_early_done", done, 0);
            @(negedge clk);
            check("err_done", done, 1);
            check("err_error", error, 1);
            check("err_no_start_at_done", bus_start_request, 0);
            check("err_load_kept", load_data, exp_load[sel]);
            @(negedge clk);
            check("err_done_one_cycle", done, 0);
            check("err_idle", busy, 0);
            return;
        end

        for (int k = 0; k < hold; k++) begin
            check("start_held", bus_start_request, 1);
            check("no_early_done", done, 0);
            check("is_write", bus_is_write, st);
            check("num_bytes", bus_num_bytes, 1 << f3[1:0]);
            check("target_addr", bus_target_address, addr);
            check("write_value", bus_write_value, model_wvalue(f3, data));
            if (success && k == hold - 1) begin
                bus_request_done = 1'b1;
                bus_fetched_value = fetched;
            end
            @(negedge clk);
        end

        if (success && !st) exp_load[sel] = model_load(f3, fetched);
        check("done_pulse", done, 1);
        check("done_error", error, !success);
        check("start_dropped", bus_start_request, 0);
        check("busy_in_release", busy, 1);
        check("load_data", load_data, exp_load[sel]);

        // Answer held (or arriving late after a timeout): must stay in release with start low.
        bus_request_done = 1'b1;
        bus_fetched_value = $urandom;
        @(negedge clk);
        check("release_busy", busy, 1);
        check("release_done_low", done, 0);
        check("release_start_low", bus_start_request, 0);
        @(negedge clk);
        check("release_busy2", busy, 1);
        bus_request_done = 1'b0;
        @(negedge clk);
        check("back_to_idle", busy, 0);
        check("load_data_after", load_data, exp_load[sel]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
        check({tag, "_start"}, bus_start_request, 0);
        check({tag, "_is_write"}, bus_is_write, 0);
        check({tag, "_num_bytes"}, bus_num_bytes, 1);
        check({tag, "_target"}, bus_target_address, 0);
        check({tag, "_wvalue"}, bus_write_value, 0);
        check({tag, "_load_data"}, load_data, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ld_codes [5];
        logic [2:0] f3;
        logic [AW-1:0] a;
        bit st;
        int d;
        ld_codes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        sel = 1'b0; rst = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_store_data = '0;
        bus_request_done = 1'b0; bus_fetched_value = '0;
        exp_load[0] = '0; exp_load[1] = '0;
        repeat (3) @(negedge clk);
        check_reset_values("rst0");
        sel = 1'b1; #1;
        check_reset_values("rst1");
        sel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 3'b010, 18'h00010, 32'h0, 20, 32'hDEADBEEF);
        run_txn(1'b0, 3'b000, 18'h00003, 32'h0, 2, 32'h00000080);
        run_txn(1'b0, 3'b100, 18'h00003, 32'h0, 3, 32'h00000080);
        run_txn(1'b0, 3'b001, 18'h00004, 32'h0, 1, 32'h00008001);
        run_txn(1'b0, 3'b101, 18'h00006, 32'h0, 2, 32'h00008001);
        run_txn(1'b1, 3'b001, 18'h10002, 32'h12345678, 4, 32'h0);
        run_txn(1'b1, 3'b000, 18'h10005, 32'hCAFEF00D, 1, 32'h0);
        run_txn(1'b0, 3'b010, 18'h00002, 32'h0, 1, 32'h11111111);
        run_txn(1'b0, 3'b011, 18'h00000, 32'h0, 1, 32'h11111111);
        run_txn(1'b1, 3'b100, 18'h00000, 32'h0, 1, 32'h0);
        run_txn(1'b1, 3'b010, 18'h20001, 32'h0, 1, 32'h0);

        sel = 1'b1;
        @(negedge clk);
        run_txn(1'b0, 3'b010, 18'h00020, 32'h0, 0, 32'h0);
        run_txn(1'b0, 3'b010, 18'h00024, 32'h0, 16, 32'hA5A55A5A);
        run_txn(1'b0, 3'b001, 18'h00030, 32'h0, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 3) != 0) f3 = st ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom);
            a = AW'($urandom);
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
            run_txn(st, f3, a, $urandom, d, $urandom);
        end

        // Reset in the middle of a request must drop start_request asynchronously.
        sel = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 18'h00040;
        @(negedge clk);
        req_valid = 1'b0;
        check("pre_reset_start", bus_start_request, 1);
        #2 rst = 1'b1;
        #1;
        check_reset_values("mid_rst");
        exp_load[0] = '0; exp_load[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(1'b0, 3'b100, 18'h20001, 32'h0, 3, 32'h000000C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
